da_tlc5615_tx: RTL



---
 rtl/da_tlc5615_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/da_tlc5615_tx.sv
// -----------------------------------------------------------------------------
// da_tlc5615_tx
// Serial transmitter for the TLC5615 10-bit DAC. A Start_Sig accepted in IDLE
// captures Data_In and shifts out one 16-bit frame MSB-first:
// {4'b0000, code[9:0], 2'b00}. Data changes only on DA_Clk falling edges, so it
// is stable across every DA_Clk rising edge, where the DAC samples it.
//
// Ports
//   CLK            system clock (50 MHz)
//   RST            synchronous reset, active-high
//   Start_Sig      send request, honoured only in IDLE
//   Data_In[9:0]   DAC code, captured when Start_Sig is accepted
//   DA_CSn         DAC chip select (active-low); its rising edge updates the DAC
//   DA_Clk         DAC serial clock, period 2*CLK_DIV
//   DA_DigData_Out DAC serial data, MSB first
//   Busy           high from the cycle after acceptance through the Done_Sig cycle
//   Done_Sig       one-cycle pulse on the last cycle of the frame
//   Last_Data[9:0] code of the last completed frame
// -----------------------------------------------------------------------------
module da_tlc5615_tx #(
    parameter int CLK_DIV    = 25,  // CLK cycles per DA_Clk half-period, 2..255
    parameter int FRAME_BITS = 16   // fixed by the TLC5615 16-bit mode
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start_Sig,
    input  logic [9:0] Data_In,
    output logic       DA_CSn,
    output logic       DA_Clk,
    output logic       DA_DigData_Out,
    output logic       Busy,
    output logic       Done_Sig,
    output logic [9:0] Last_Data
);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_PRE  = 8'(CLK_DIV - 2);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    state_t                  state;
    logic [7:0]              div_cnt;
    logic [3:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   shreg;
    logic [9:0]              code;
    logic                    div_end;

    assign div_end = (div_cnt == DIV_LAST);

    // Serial data is the MSB of the shift register itself. The register is all
    // zero outside a frame and after the final shift, so the line idles low
    // in HOLD/GAP/IDLE without a separate mux.
    assign DA_DigData_Out = shreg[FRAME_BITS-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            code      <= '0;
            DA_CSn    <= 1'b1;
            DA_Clk    <= 1'b0;
            Busy      <= 1'b0;
            Done_Sig  <= 1'b0;
            Last_Data <= '0;
        end else begin
            Done_Sig <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start_Sig) begin
                        shreg   <= {4'b0000, Data_In, 2'b00};
                        code    <= Data_In;
                        bit_cnt <= BIT_LAST;
                        div_cnt <= '0;
                        DA_CSn  <= 1'b0;
                        Busy    <= 1'b1;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        DA_Clk  <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        DA_Clk  <= 1'b0;
                        // Shift on the falling edge; the last shift flushes
                        // the register to zero so data is low during HOLD.
                        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                        if (bit_cnt == 4'd0) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        DA_CSn  <= 1'b1;
                        bit_cnt <= 4'd1;  // GAP is two CLK_DIV periods
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    // Done/Last_Data are registered, so they are loaded one
                    // edge early to land on the final GAP cycle.
                    if (bit_cnt == 4'd0 && div_cnt == DIV_PRE) begin
                        Done_Sig  <= 1'b1;
                        Last_Data <= code;
                    end
                    if (div_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == 4'd0) begin
                            Busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            bit_cnt <= 4'd0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
